stage_writeback: RTL
====================

STAGE_WRITEBACK -- requirements
Module: stage_writeback

Interface
Parameters:
REQ-001 The block SHALL have parameter WD_SIZE, default 32, register data width.
REQ-002 The block SHALL have parameter INSTR_REG_BITS, default 5, register index width.
REQ-003 The block SHALL have parameter ALU_FIFO_DEPTH, default 2, number of ALU results held while the memory path owns the write port; any value >= 1 SHALL be supported.

Ports:
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 alu_valid  in  1  ALU result offered this cycle.
REQ-007 alu_ready  out  1  ALU result accepted when alu_valid & alu_ready.
REQ-008 alu_rd  in  INSTR_REG_BITS  destination register of ALU result.
REQ-009 alu_data  in  WD_SIZE  ALU result.
REQ-010 mem_valid  in  1  load data returned this cycle; always accepted, no ready.
REQ-011 mem_rd  in  INSTR_REG_BITS  destination register of load.
REQ-012 mem_funct3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-013 mem_offset  in  2  byte address bits [1:0] of the load.
REQ-014 mem_data  in  WD_SIZE  raw aligned memory word.
REQ-015 wr_en  out  1  register-file write strobe.
REQ-016 wr_rd  out  INSTR_REG_BITS  register-file write index.
REQ-017 wr_data  out  WD_SIZE  register-file write data.
REQ-018 busy  out  1  high when the ALU FIFO holds at least one entry.

Function
REQ-019 wr_en, wr_rd and wr_data SHALL be registered; a result selected in cycle N SHALL appear on them in cycle N+1 for exactly one cycle.
REQ-020 When no result is selected, wr_en SHALL be 0 and wr_rd and wr_data SHALL hold their previous values.
REQ-021 Each cycle, selection priority SHALL be: (1) mem_valid load; (2) ALU FIFO head; (3) a newly accepted ALU result, only when the FIFO is empty.
REQ-022 Every accepted ALU result not selected in its acceptance cycle SHALL be pushed into the FIFO.
REQ-023 ALU results SHALL be written in acceptance order; a FIFO entry is never bypassed by a newer ALU result.
REQ-024 alu_ready SHALL be driven from registered state only: 1 when FIFO count < ALU_FIFO_DEPTH, else 0; it has no combinational path from any input.
REQ-025 A pop and a push in the same cycle SHALL leave the count unchanged; read and write pointers SHALL wrap modulo ALU_FIFO_DEPTH.
REQ-026 While mem_valid is held high, the FIFO SHALL not drain and alu_ready SHALL fall once the FIFO is full; no ALU result is ever lost or duplicated.
REQ-027 Any result (ALU or load) with rd == 0 SHALL be consumed without a write: wr_en stays 0, no FIFO slot is used, and a lower-priority candidate may be selected that cycle.
REQ-028 Load formatting: LB/LBU SHALL select byte mem_data[8*offset +: 8].
REQ-029 Load formatting: LH/LHU SHALL select halfword mem_data[16*offset[1] +: 16], ignoring offset[0].
REQ-030 Load formatting: LW and all other funct3 codes SHALL pass mem_data unchanged.
REQ-031 LB/LH SHALL sign-extend to WD_SIZE; LBU/LHU SHALL zero-extend.
REQ-032 busy SHALL equal (FIFO count != 0).
REQ-033 WAW ordering between a load and an ALU result to the same rd is upstream's responsibility and SHALL NOT be checked here.

Reset
REQ-034 While reset is high at a clock edge: FIFO count = 0, both pointers = 0, wr_en = 0, wr_rd = 0, wr_data = 0; therefore alu_ready = 1 and busy = 0 in the next cycle.
REQ-035 Reset asserted mid-operation SHALL discard all FIFO contents and any selected result, with no write on the cycle after reset.
REQ-036 Inputs presented while reset is high SHALL be ignored.

Verification
REQ-037 ALU only: alu_valid=1, rd=5, data=0x1234 with FIFO empty -> next cycle wr_en=1, wr_rd=5, wr_data=0x1234, busy=0.
REQ-038 Loads: mem LB with offset=2, data=0x0080_0000, rd=3 -> wr_data=0xFFFF_FF80; LHU with offset=2, data=0x8001_0000 -> wr_data=0x0000_8001.
REQ-039 Conflict: mem_valid and alu_valid both in cycle 0 (mem rd=1, ALU rd=2) -> cycle 1 writes rd=1, cycle 2 writes rd=2, busy=1 during cycle 1.
REQ-040 Full FIFO: mem_valid held for 4 cycles with ALU results A, B, C offered (depth 2) -> alu_ready=0 after A and B are accepted; C is held; after mem_valid drops, writes occur in order A, B, C.
REQ-041 x0 drop: ALU rd=0 then rd=7 back-to-back -> only one write, rd=7; count stays 0.
REQ-042 Reset with 2 FIFO entries -> no write on the following cycle; alu_ready=1 and busy=0.

Source files
------------

// File: rtl/stage_writeback.sv
// Writeback stage: merges returning loads and ALU results onto one registered
// register-file write port. Loads have priority; ALU results queue in a small FIFO.
module stage_writeback #(
  parameter int unsigned WD_SIZE        = 32,
  parameter int unsigned INSTR_REG_BITS = 5,
  parameter int unsigned ALU_FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [INSTR_REG_BITS-1:0] alu_rd,
  input  logic [WD_SIZE-1:0]        alu_data,
  input  logic                      mem_valid,
  input  logic [INSTR_REG_BITS-1:0] mem_rd,
  input  logic [2:0]                mem_funct3,
  input  logic [1:0]                mem_offset,
  input  logic [WD_SIZE-1:0]        mem_data,
  output logic                      wr_en,
  output logic [INSTR_REG_BITS-1:0] wr_rd,
  output logic [WD_SIZE-1:0]        wr_data,
  output logic                      busy
);

  localparam int unsigned PTR_W = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(ALU_FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ALU_FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ALU_FIFO_DEPTH);

  logic [INSTR_REG_BITS-1:0] fifo_rd   [ALU_FIFO_DEPTH];
  logic [WD_SIZE-1:0]        fifo_data [ALU_FIFO_DEPTH];
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W-1:0]          wr_ptr;
  logic [CNT_W-1:0]          count;

  logic                      accept;
  logic                      alu_live;
  logic                      mem_live;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      sel_en;
  logic [INSTR_REG_BITS-1:0] sel_rd;
  logic [WD_SIZE-1:0]        sel_data;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [WD_SIZE-1:0]        ld_value;

  assign alu_ready  = (count < CNT_FULL);
  assign busy       = (count != '0);
  assign fifo_empty = (count == '0);

  // Load alignment and extension
  always_comb begin
    ld_byte  = '0;
    ld_half  = '0;
    ld_value = mem_data;
    case (mem_offset)
      2'd0:    ld_byte = mem_data[7:0];
      2'd1:    ld_byte = mem_data[15:8];
      2'd2:    ld_byte = mem_data[23:16];
      default: ld_byte = mem_data[31:24];
    endcase
    ld_half = mem_offset[1] ? mem_data[31:16] : mem_data[15:0];
    case (mem_funct3)
      3'b000:  ld_value = {{(WD_SIZE-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{(WD_SIZE-16){ld_half[15]}}, ld_half};
      3'b100:  ld_value = {{(WD_SIZE-8){1'b0}}, ld_byte};
      3'b101:  ld_value = {{(WD_SIZE-16){1'b0}}, ld_half};
      default: ld_value = mem_data;
    endcase
  end

  // Results targeting x0 are consumed here and never occupy the port or the FIFO,
  // so the next candidate in priority order can use the port in the same cycle.
  always_comb begin
    accept   = alu_valid & alu_ready;
    alu_live = accept & (alu_rd != '0);
    mem_live = mem_valid & (mem_rd != '0);
    sel_en   = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    pop      = 1'b0;
    push     = 1'b0;
    if (mem_live) begin
      sel_en   = 1'b1;
      sel_rd   = mem_rd;
      sel_data = ld_value;
      push     = alu_live;
    end else if (!fifo_empty) begin
      sel_en   = 1'b1;
      sel_rd   = fifo_rd[rd_ptr];
      sel_data = fifo_data[rd_ptr];
      pop      = 1'b1;
      push     = alu_live;
    end else if (alu_live) begin
      sel_en   = 1'b1;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      wr_en   <= 1'b0;
      wr_rd   <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= sel_en;
      if (sel_en) begin
        wr_rd   <= sel_rd;
        wr_data <= sel_data;
      end
      if (push) begin
        fifo_rd[wr_ptr]   <= alu_rd;
        fifo_data[wr_ptr] <= alu_data;
        wr_ptr            <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
